k12a_mem_arbiter: RTL and testbench

//  Shares the k12a memory subsystem (32 KiB ROM at 0x0000-0x7FFF, 32 KiB RAM at 0x8000-0xFFFF)

---
 rtl/k12a_mem_arbiter_if.sv | 48 ++++
 rtl/k12a_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_k12a_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/k12a_mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the k12a arbiter and the async memory block.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface k12a_mem_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;

   logic        dma_req;
   logic        dma_we;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_ack;
   logic [7:0]  dma_rdata;

   logic [15:0] mem_addr;
   logic        mem_addr_oe;
   logic [7:0]  mem_data_out;
   logic        mem_data_oe;
   logic [7:0]  mem_data_in;
   logic        mem_rom_ce_n;
   logic        mem_ram_ce_n;
   logic        mem_oe_n;
   logic        mem_we_n;
   logic        busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ack, dma_rdata,
      output mem_addr, mem_addr_oe, mem_data_out, mem_data_oe,
      input  mem_data_in,
      output mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ack, dma_rdata,
      input  mem_addr, mem_addr_oe, mem_data_out, mem_data_oe,
      output mem_data_in,
      input  mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n, busy
   );
endinterface

// File: rtl/k12a_mem_arbiter.sv
// CPU/DMA arbiter for the k12a ROM/RAM with programmable setup/pulse/hold strobe timing.
// Define K12A_MEM_ARB_ROUND_ROBIN_EN for round-robin; default build is fixed CPU priority.
//
// state    | meaning
// ST_IDLE  | no transaction; also the turnaround cycle in which ack is visible
// ST_SETUP | address and chip enable valid, oe_n/we_n high
// ST_PULSE | oe_n (read) or we_n (RAM write) low; read data sampled on last cycle
// ST_HOLD  | strobes released, address/ce/data held; ack issued on last cycle
module k12a_mem_arbiter #(
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned PULSE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES  = 1
) (
   input logic               clock_i,
   input logic               reset_i,
   k12a_mem_arbiter_if.slave bus_if
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} state_t;

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYCLES - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_we_q, op_we_d;
   logic        op_dma_q, op_dma_d;
   logic [15:0] op_addr_q, op_addr_d;
   logic [7:0]  op_wdata_q, op_wdata_d;
   logic [7:0]  rd_q, rd_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic [7:0]  dma_rdata_q, dma_rdata_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        dma_ack_q, dma_ack_d;
   logic        rom_ce_n_q, rom_ce_n_d;
   logic        ram_ce_n_q, ram_ce_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic        addr_oe_q, addr_oe_d;
   logic        data_oe_q, data_oe_d;
   logic        start_go;
   logic        grant_dma;

   // No grant while an ack is visible, so the ack cycle is always a bus turnaround.
   assign start_go = (state_q == ST_IDLE) && !cpu_ack_q && !dma_ack_q &&
                     (bus_if.cpu_req || bus_if.dma_req);

`ifdef K12A_MEM_ARB_ROUND_ROBIN_EN
   logic rr_dma_q, rr_dma_d;

   always_comb grant_dma = bus_if.dma_req && (!bus_if.cpu_req || rr_dma_q);

   always_comb begin
      rr_dma_d = rr_dma_q;
      if (start_go) rr_dma_d = !grant_dma;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) rr_dma_q <= 1'b0;
      else         rr_dma_q <= rr_dma_d;
   end
`else
   always_comb grant_dma = !bus_if.cpu_req;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_we_d     = op_we_q;
      op_dma_d    = op_dma_q;
      op_addr_d   = op_addr_q;
      op_wdata_d  = op_wdata_q;
      rd_d        = rd_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_go) begin
               op_dma_d   = grant_dma;
               op_we_d    = grant_dma ? bus_if.dma_we    : bus_if.cpu_we;
               op_addr_d  = grant_dma ? bus_if.dma_addr  : bus_if.cpu_addr;
               op_wdata_d = grant_dma ? bus_if.dma_wdata : bus_if.cpu_wdata;
               state_d    = ST_SETUP;
               cnt_d      = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_PULSE: begin
            if (cnt_q == 4'd0) begin
               rd_d    = bus_if.mem_data_in;
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
               if (op_dma_q) begin
                  dma_ack_d = 1'b1;
                  if (!op_we_q) dma_rdata_d = rd_q;
               end else begin
                  cpu_ack_d = 1'b1;
                  if (!op_we_q) cpu_rdata_d = rd_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Strobes are registered from the next state so they change cleanly on the edge.
      addr_oe_d  = (state_d != ST_IDLE);
      data_oe_d  = (state_d != ST_IDLE) && op_we_d;
      rom_ce_n_d = !((state_d != ST_IDLE) && !op_addr_d[15]);
      ram_ce_n_d = !((state_d != ST_IDLE) &&  op_addr_d[15]);
      oe_n_d     = !((state_d == ST_PULSE) && !op_we_d);
      we_n_d     = !((state_d == ST_PULSE) &&  op_we_d && op_addr_d[15]);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         op_we_q     <= 1'b0;
         op_dma_q    <= 1'b0;
         op_addr_q   <= 16'h0000;
         op_wdata_q  <= 8'h00;
         rd_q        <= 8'h00;
         cpu_rdata_q <= 8'h00;
         dma_rdata_q <= 8'h00;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         rom_ce_n_q  <= 1'b1;
         ram_ce_n_q  <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         addr_oe_q   <= 1'b0;
         data_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_we_q     <= op_we_d;
         op_dma_q    <= op_dma_d;
         op_addr_q   <= op_addr_d;
         op_wdata_q  <= op_wdata_d;
         rd_q        <= rd_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         rom_ce_n_q  <= rom_ce_n_d;
         ram_ce_n_q  <= ram_ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         addr_oe_q   <= addr_oe_d;
         data_oe_q   <= data_oe_d;
      end
   end

   assign bus_if.cpu_ack      = cpu_ack_q;
   assign bus_if.cpu_rdata    = cpu_rdata_q;
   assign bus_if.dma_ack      = dma_ack_q;
   assign bus_if.dma_rdata    = dma_rdata_q;
   assign bus_if.mem_addr     = op_addr_q;
   assign bus_if.mem_addr_oe  = addr_oe_q;
   assign bus_if.mem_data_out = op_wdata_q;
   assign bus_if.mem_data_oe  = data_oe_q;
   assign bus_if.mem_rom_ce_n = rom_ce_n_q;
   assign bus_if.mem_ram_ce_n = ram_ce_n_q;
   assign bus_if.mem_oe_n     = oe_n_q;
   assign bus_if.mem_we_n     = we_n_q;
   assign bus_if.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// Bench for k12a_mem_arbiter: async ROM/RAM device model plus an array-based reference
// memory; directed scenarios followed by randomized single-requester traffic.
module tb_k12a_mem_arbiter;
   localparam int S = 1;
   localparam int P = 2;
   localparam int H = 1;
   localparam int LAT = 1 + S + P + H;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   k12a_mem_arbiter_if bus_if ();

   k12a_mem_arbiter dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus_if  (bus_if)
   );

   function automatic logic [7:0] rom_init(input int a);
      if (a == 16'h0123) return 8'h5A;
      return 8'((a * 37) ^ (a >> 7) ^ 8'h96);
   endfunction

   function automatic logic [7:0] ram_init(input int a);
      return 8'((a * 11) + 5);
   endfunction

   // Async memory device: reads while oe_n low, RAM writes while we_n low.
   logic [7:0] dev_rom [0:32767];
   logic [7:0] dev_ram [0:32767];
   logic       dev_ready = 1'b0;

   initial for (int i = 0; i < 32768; i++) dev_rom[i] = rom_init(i);

   always @(posedge clock) begin
      if (!dev_ready) begin
         for (int i = 0; i < 32768; i++) dev_ram[i] <= ram_init(i);
         dev_ready <= 1'b1;
      end else if (!bus_if.mem_we_n && !bus_if.mem_ram_ce_n && bus_if.mem_data_oe) begin
         dev_ram[bus_if.mem_addr[14:0]] <= bus_if.mem_data_out;
      end
   end

   assign bus_if.mem_data_in =
      (!bus_if.mem_oe_n && bus_if.mem_addr_oe) ?
         (!bus_if.mem_rom_ce_n ? dev_rom[bus_if.mem_addr[14:0]] :
          (!bus_if.mem_ram_ce_n ? dev_ram[bus_if.mem_addr[14:0]] : 8'hFF)) : 8'hFF;

   // Reference memory contents as seen by requesters.
   logic [7:0] ref_ram [0:32767];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_rom = 0, n_ram = 0, n_oe = 0, n_we = 0;
   bit mon_en = 1'b0;
   bit cur_we = 1'b0;
   bit prev_cpu_ack = 1'b0, prev_dma_ack = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample #1 after the edge, check bus invariants, accumulate strobe cycles.
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (mon_en) begin
         chk("ce_onehot", {31'd0, !bus_if.mem_rom_ce_n && !bus_if.mem_ram_ce_n}, 0);
         chk("oe_we_excl", {31'd0, !bus_if.mem_oe_n && !bus_if.mem_we_n}, 0);
         chk("data_oe_wr", {31'd0, bus_if.mem_data_oe && !cur_we}, 0);
         chk("ack_pulse", {31'd0, (prev_cpu_ack && bus_if.cpu_ack) ||
                                  (prev_dma_ack && bus_if.dma_ack) ||
                                  (bus_if.cpu_ack && bus_if.dma_ack)}, 0);
      end
      prev_cpu_ack = bus_if.cpu_ack;
      prev_dma_ack = bus_if.dma_ack;
      if (!bus_if.mem_rom_ce_n) n_rom++;
      if (!bus_if.mem_ram_ce_n) n_ram++;
      if (!bus_if.mem_oe_n) n_oe++;
      if (!bus_if.mem_we_n && bus_if.mem_data_oe) n_we++;
   endtask

   function automatic logic [7:0] ref_read(input logic [15:0] a);
      return a[15] ? ref_ram[a[14:0]] : rom_init(int'(a[14:0]));
   endfunction

   // Single transaction from one port, checked for latency, strobes and data.
   task automatic xfer(input bit dma, input bit we, input logic [15:0] addr, input logic [7:0] wd);
      int lat;
      bit got;
      int r0, m0, o0, w0;
      logic [7:0] other0, rd, exp_rd;
      cur_we = we;
      r0 = n_rom; m0 = n_ram; o0 = n_oe; w0 = n_we;
      other0 = dma ? bus_if.cpu_rdata : bus_if.dma_rdata;
      exp_rd = ref_read(addr);
      if (dma) begin
         bus_if.dma_we = we; bus_if.dma_addr = addr; bus_if.dma_wdata = wd; bus_if.dma_req = 1'b1;
      end else begin
         bus_if.cpu_we = we; bus_if.cpu_addr = addr; bus_if.cpu_wdata = wd; bus_if.cpu_req = 1'b1;
      end
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         lat++;
         if (dma ? bus_if.dma_ack : bus_if.cpu_ack) got = 1'b1;
      end
      bus_if.cpu_req = 1'b0;
      bus_if.dma_req = 1'b0;
      rd = dma ? bus_if.dma_rdata : bus_if.cpu_rdata;
      chk("ack_seen", {31'd0, got}, 1);
      chk("latency", lat, LAT);
      chk("rom_ce_cycles", n_rom - r0, addr[15] ? 0 : S + P + H);
      chk("ram_ce_cycles", n_ram - m0, addr[15] ? S + P + H : 0);
      chk("oe_cycles", n_oe - o0, we ? 0 : P);
      chk("we_cycles", n_we - w0, (we && addr[15]) ? P : 0);
      chk("other_rdata", {24'd0, dma ? bus_if.cpu_rdata : bus_if.dma_rdata}, {24'd0, other0});
      if (!we) chk("rdata", {24'd0, rd}, {24'd0, exp_rd});
      else if (addr[15]) ref_ram[addr[14:0]] = wd;
      step();
   endtask

   initial begin
      int nacks, nexp;
      bit who [0:7];
      int acyc [0:7];
      bit found;
      logic [7:0] old_b, v;
      logic [15:0] a;

      for (int i = 0; i < 32768; i++) ref_ram[i] = ram_init(i);
      reset = 1'b1;
      bus_if.cpu_req = 1'b0; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = '0; bus_if.cpu_wdata = '0;
      bus_if.dma_req = 1'b0; bus_if.dma_we = 1'b0; bus_if.dma_addr = '0; bus_if.dma_wdata = '0;
      repeat (3) step();

      chk("rst_strobes", {28'd0, bus_if.mem_rom_ce_n, bus_if.mem_ram_ce_n,
                          bus_if.mem_oe_n, bus_if.mem_we_n}, 32'hF);
      chk("rst_enables", {30'd0, bus_if.mem_addr_oe, bus_if.mem_data_oe}, 0);
      chk("rst_addr_data", {8'd0, bus_if.mem_addr, bus_if.mem_data_out}, 0);
      chk("rst_acks_busy", {29'd0, bus_if.cpu_ack, bus_if.dma_ack, bus_if.busy}, 0);
      chk("rst_rdata", {16'd0, bus_if.cpu_rdata, bus_if.dma_rdata}, 0);
      reset = 1'b0;
      mon_en = 1'b1;
      step();

      // Directed: ROM read, RAM write then read, ROM write dropped
      xfer(1'b0, 1'b0, 16'h0123, 8'h00);
      xfer(1'b1, 1'b1, 16'h8010, 8'hC3);
      xfer(1'b0, 1'b0, 16'h8010, 8'h00);
      xfer(1'b0, 1'b1, 16'h0040, 8'h77);
      xfer(1'b0, 1'b0, 16'h0040, 8'h00);

      // Randomized single-requester traffic
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) a = {1'b0, 15'($urandom)};
         else a = {1'b1, 7'd0, 8'($urandom_range(0, 15))};
         xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom));
      end

      // Reset during the write pulse of a RAM write
      a = 16'h8055;
      old_b = ref_ram[a[14:0]];
      cur_we = 1'b1;
      bus_if.dma_we = 1'b1; bus_if.dma_addr = a; bus_if.dma_wdata = 8'hE1; bus_if.dma_req = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (!bus_if.mem_we_n) found = 1'b1;
      end
      chk("we_pulse_seen", {31'd0, found}, 1);
      reset = 1'b1;
      bus_if.dma_req = 1'b0;
      step();
      chk("abort_strobes", {28'd0, bus_if.mem_rom_ce_n, bus_if.mem_ram_ce_n,
                            bus_if.mem_oe_n, bus_if.mem_we_n}, 32'hF);
      chk("abort_enables", {30'd0, bus_if.mem_addr_oe, bus_if.mem_data_oe}, 0);
      chk("abort_busy_ack", {29'd0, bus_if.busy, bus_if.cpu_ack, bus_if.dma_ack}, 0);
      chk("abort_rdata", {16'd0, bus_if.cpu_rdata, bus_if.dma_rdata}, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("abort_no_ack", {30'd0, bus_if.cpu_ack, bus_if.dma_ack}, 0);
      end
      cur_we = 1'b0;
      bus_if.dma_we = 1'b0; bus_if.dma_req = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (bus_if.dma_ack) found = 1'b1;
      end
      bus_if.dma_req = 1'b0;
      v = bus_if.dma_rdata;
      chk("abort_read_ack", {31'd0, found}, 1);
      chk("abort_byte_old_or_new", {31'd0, (v === old_b) || (v === 8'hE1)}, 1);
      ref_ram[a[14:0]] = v;
      step();

      // Both requesters held: arbitration order and service period
      cur_we = 1'b0;
      bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 16'h8010;
      bus_if.dma_we = 1'b0; bus_if.dma_addr = 16'h0123;
`ifdef K12A_MEM_ARB_ROUND_ROBIN_EN
      nexp = 4;
`else
      nexp = 5;
`endif
      bus_if.cpu_req = 1'b1;
      bus_if.dma_req = 1'b1;
      nacks = 0;
      for (int i = 0; i < 80 && nacks < nexp; i++) begin
         step();
         if (bus_if.cpu_ack || bus_if.dma_ack) begin
            who[nacks] = bus_if.dma_ack;
            acyc[nacks] = i + 1;
            chk("held_rdata", {24'd0, bus_if.dma_ack ? bus_if.dma_rdata : bus_if.cpu_rdata},
                {24'd0, ref_read(bus_if.dma_ack ? 16'h0123 : 16'h8010)});
            nacks++;
            if (nacks == 4) bus_if.cpu_req = 1'b0;
            if (nacks == nexp) bus_if.dma_req = 1'b0;
         end
      end
      bus_if.cpu_req = 1'b0;
      bus_if.dma_req = 1'b0;
      chk("held_ack_count", nacks, nexp);
      for (int k = 0; k < nacks; k++) begin
`ifdef K12A_MEM_ARB_ROUND_ROBIN_EN
         chk("held_grant_order", {31'd0, who[k]}, {31'd0, 1'(k % 2)});
`else
         chk("held_grant_order", {31'd0, who[k]}, {31'd0, k == 4});
`endif
         if (k == 0) chk("held_first_lat", acyc[k], LAT);
         else chk("held_period", acyc[k] - acyc[k-1], LAT + 1);
      end
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
